conf_reg_bank: RTL
==================

// Module: conf_reg_bank
// PURPOSE
//  DUT-side consumer of the configuration channel (c_addr/c_data/c_valid in, c_ready out).
//  Accepts one write per valid/ready handshake and commits it into a bank of NUM_REGS registers.
//  Presents all registers in parallel to the datapath, with a one-cycle update strobe.
//  Counts committed writes; flags writes to out-of-range addresses.
// PARAMETERS
//  ADDR_W     c_addr_WIDTH (item_pack)  width of c_addr
//  DATA_W     c_data_WIDTH (item_pack)  width of c_data and of each register
//  NUM_REGS   16                        registers implemented; valid addresses 0..NUM_REGS-1
//  RESET_VAL  '0                        reset value of every register
//  CNT_W      16                        width of wr_count
// PORTS
//  clk          in   1                 single clock; all logic on posedge
//  rst_n        in   1                 asynchronous reset, active low
//  c_addr       in   ADDR_W            config address, sampled only on handshake
//  c_data       in   DATA_W            config data, sampled only on handshake
//  c_valid      in   1                 write request
//  c_ready      out  1                 bank can accept a write this cycle (registered)
//  cfg_q        out  NUM_REGS*DATA_W   register contents; reg i at [i*DATA_W +: DATA_W]
//  cfg_upd      out  1                 one-cycle pulse: a register was just written
//  cfg_upd_idx  out  $clog2(NUM_REGS)  index written; meaningful only while cfg_upd=1
//  c_err        out  1                 sticky: out-of-range write seen since reset
//  wr_count     out  CNT_W             committed in-range writes, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): state=INIT, c_ready=0, cfg_upd=0, cfg_upd_idx=0,
//    c_err=0, wr_count=0, all registers=RESET_VAL.
//  - FSM: INIT -> IDLE on the first edge after release (c_ready=1 after that edge).
//    IDLE: c_ready=1; on edge E0 with c_valid=1, latch c_addr/c_data into the hold register,
//    go to COMMIT, c_ready=0.
//    COMMIT: on E1, if hold_addr<NUM_REGS, write the register, cfg_upd=1,
//    cfg_upd_idx=hold_addr, wr_count+1.
//    Otherwise c_err=1 and no register, cfg_upd or wr_count change.
//    Always return to IDLE with c_ready=1.
//  - Latency: new cfg_q value and cfg_upd are visible after E1 (1 cycle after handshake).
//    The next handshake can occur no earlier than E2. Peak throughput is 1 write / 2 cycles.
//  - c_valid while c_ready=0 is ignored, nothing is captured. Upstream holds its request until
//    a cycle where c_ready was high. Bus values with c_valid=0 are don't-care, including X.
//  - cfg_upd is high for exactly one cycle per in-range write and is never asserted in
//    INIT or IDLE-without-commit.
//  - The same address may be written back to back; the last value wins and each write pulses.
//  - wr_count saturates at 2**CNT_W-1; no wrap.
//  - c_err is cleared only by reset.
//  - Reset mid-COMMIT: the pending write is discarded; state is as at reset.
//  - Address compare is unsigned on full ADDR_W bits. Upper address bits are not aliased.
// STRUCTURE
//  - item_pack gains: typedef enum logic [1:0] {CONF_INIT, CONF_IDLE, CONF_COMMIT} conf_state_e;
//    plus a CONF_NUM_REGS constant shared with the testbench scoreboard.
//    c_addr_WIDTH and c_data_WIDTH stay in item_pack.
//  - One sub-module, conf_reg_array, holds the register storage only.
//    Inputs: clk, rst_n, we, widx, wdata. Output: flattened q.
//    It has no knowledge of the handshake.
//  - The top level holds the FSM, the hold register, the error and count logic, and the
//    output registers.
// TESTING
//  1 Reset/init: hold rst_n=0 for 3 cycles -> c_ready=0, cfg_q all 0; c_ready=1 exactly
//    1 cycle after release.
//  2 Single write: addr=3, data=0xA5, valid for 1 cycle -> c_ready=0 next cycle;
//    cfg_upd=1, idx=3 next; reg3=0xA5; wr_count=1.
//  3 Back-to-back: valid held high with addr 0..15 / data=addr+1 -> 16 pulses, 2 cycles apart;
//    reg[i]=i+1; wr_count=16; no writes are lost or duplicated.
//  4 Out of range: addr=NUM_REGS (16), data=0xFF -> c_err=1; no cfg_upd; cfg_q and wr_count
//    unchanged. A following in-range write works normally and c_err stays 1.
//  5 Reset mid-commit: handshake addr=5, data=0x3C, then assert rst_n=0 in the COMMIT cycle
//    -> reg5=0, no cfg_upd, wr_count=0.
//  6 Saturation with CNT_W=2: 5 in-range writes -> wr_count sequence 1, 2, 3, 3, 3.
//    Also: X on c_addr with c_valid=0 -> no capture, no X on any output.

Source files
------------

// File: rtl/item_pack.sv
// Shared configuration-channel definitions.
//  c_addr_WIDTH / c_data_WIDTH : configuration bus widths
//  CONF_NUM_REGS               : register count of the bank (shared with the bench model)
//  conf_state_e                : conf_reg_bank FSM states
package item_pack;
  localparam int c_addr_WIDTH  = 8;
  localparam int c_data_WIDTH  = 8;
  localparam int CONF_NUM_REGS = 16;

  typedef enum logic [1:0] {CONF_INIT, CONF_IDLE, CONF_COMMIT} conf_state_e;
endpackage

// File: rtl/conf_reg_bank_if.sv
// Configuration write channel: valid/ready handshake carrying addr + data.
//  master : drives c_addr, c_data, c_valid; observes c_ready
//  slave  : observes c_addr, c_data, c_valid; drives c_ready
interface conf_reg_bank_if import item_pack::*; #(
  parameter int ADDR_W = c_addr_WIDTH,
  parameter int DATA_W = c_data_WIDTH
);
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              c_valid;
  logic              c_ready;

  modport master (output c_addr, c_data, c_valid, input  c_ready);
  modport slave  (input  c_addr, c_data, c_valid, output c_ready);
endinterface

// File: rtl/conf_reg_array.sv
// Register storage for the configuration bank. Pure storage: one write
// port, all registers read out in parallel.
//  clk, rst_n : clock, async active-low reset (registers -> RESET_VAL)
//  we         : write enable
//  widx       : register index to write
//  wdata      : write data
//  q          : flattened contents, reg i at [i*DATA_W +: DATA_W]
module conf_reg_array import item_pack::*; #(
  parameter int              NUM_REGS  = CONF_NUM_REGS,
  parameter int              DATA_W    = c_data_WIDTH,
  parameter int              IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [NUM_REGS*DATA_W-1:0] q
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          regs[i] <= RESET_VAL;
      else if (we && widx == IDX_W'(i))    regs[i] <= wdata;
    end
  end

  assign q = regs;
endmodule

// File: rtl/conf_reg_bank.sv
// Configuration register bank: accepts one write per c_valid/c_ready
// handshake, commits it one cycle later into NUM_REGS registers, and
// presents all registers in parallel with a one-cycle update strobe.
//  clk, rst_n   : clock, async active-low reset
//  cif          : configuration channel (slave side)
//  cfg_q        : register contents, reg i at [i*DATA_W +: DATA_W]
//  cfg_upd      : one-cycle pulse per committed in-range write
//  cfg_upd_idx  : index written, valid while cfg_upd=1
//  c_err        : sticky out-of-range write flag (cleared by reset only)
//  wr_count     : committed in-range writes, saturating
module conf_reg_bank import item_pack::*; #(
  parameter int                ADDR_W    = c_addr_WIDTH,
  parameter int                DATA_W    = c_data_WIDTH,
  parameter int                NUM_REGS  = CONF_NUM_REGS,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16,
  localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
  input  logic                       clk,
  input  logic                       rst_n,
  conf_reg_bank_if.slave             cif,
  output logic [NUM_REGS*DATA_W-1:0] cfg_q,
  output logic                       cfg_upd,
  output logic [IDX_W-1:0]           cfg_upd_idx,
  output logic                       c_err,
  output logic [CNT_W-1:0]           wr_count
);
  // Compare width covers both the full address and NUM_REGS so that upper
  // address bits are never dropped (no aliasing onto low registers).
  localparam int            CMP_W      = ((ADDR_W > 32) ? ADDR_W : 32) + 1;
  localparam logic [CMP_W-1:0] NUM_REGS_X = CMP_W'(NUM_REGS);

  conf_state_e       state;
  logic              c_ready_q;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              in_range;
  logic              we;

  assign in_range    = CMP_W'(hold_addr) < NUM_REGS_X;
  assign we          = (state == CONF_COMMIT) && in_range;
  assign cif.c_ready = c_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CONF_INIT;
      c_ready_q   <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      cfg_upd     <= 1'b0;
      cfg_upd_idx <= '0;
      c_err       <= 1'b0;
      wr_count    <= '0;
    end else begin
      cfg_upd <= 1'b0;
      case (state)
        CONF_INIT: begin
          state     <= CONF_IDLE;
          c_ready_q <= 1'b1;
        end
        CONF_IDLE: begin
          // Bus is only sampled here; with c_valid low its contents may be X.
          if (cif.c_valid) begin
            hold_addr <= cif.c_addr;
            hold_data <= cif.c_data;
            state     <= CONF_COMMIT;
            c_ready_q <= 1'b0;
          end
        end
        CONF_COMMIT: begin
          if (in_range) begin
            cfg_upd     <= 1'b1;
            cfg_upd_idx <= IDX_W'(hold_addr);
            if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
          end else begin
            c_err <= 1'b1;
          end
          state     <= CONF_IDLE;
          c_ready_q <= 1'b1;
        end
        default: begin
          state     <= CONF_INIT;
          c_ready_q <= 1'b0;
        end
      endcase
    end
  end

  conf_reg_array #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .widx  (IDX_W'(hold_addr)),
    .wdata (hold_data),
    .q     (cfg_q)
  );
endmodule
